pwm_ramp_ctrl: RTL and testbench

//  Soft-start/ramp sequencer that drives the pwm_top register write port (wr_en/addr/wr_data).
//  On start it programs prescaler, period, duty=0 and CTRL (enable), then steps DUTY toward a

---
 rtl/pwm_ramp_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start ramp sequencer: programs pwm_top registers, then steps DUTY toward a target.
// Optional PWM_RAMP_SOFT_STOP_EN: stop after enable ramps duty down to 0 before disabling.
module pwm_ramp_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned IW          = 16,
  parameter logic [3:0]  ADDR_CTRL   = 4'h0,
  parameter logic [3:0]  ADDR_PERIOD = 4'h1,
  parameter logic [3:0]  ADDR_DUTY   = 4'h2,
  parameter logic [3:0]  ADDR_PRESC  = 4'h3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_cfg,
  input  logic [WIDTH-1:0] presc_cfg,
  input  logic [WIDTH-1:0] period_cfg,
  input  logic [WIDTH-1:0] target_duty,
  input  logic [WIDTH-1:0] step_size,
  input  logic [IW-1:0]    interval,
  output logic             reg_wr_en,
  output logic [3:0]       reg_addr,
  output logic [WIDTH-1:0] reg_wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cur_duty
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRESC, S_PERIOD, S_DUTY0, S_CTRL, S_WAIT, S_STEP, S_DONE, S_STOP
  } state_t;

  state_t           state, next_state;
  logic             mode_q;
  logic [WIDTH-1:0] presc_q, period_q, tgt_q, step_q;
  logic [IW-1:0]    ivl_q, cnt_q;

  logic             soft_take, soft_act, stop_hit, at_tgt;
  logic [WIDTH-1:0] eff_tgt, step_val;
  logic [WIDTH:0]   up_sum, dn_diff;

  logic             wr_en_d, done_d, busy_d;
  logic [3:0]       addr_d;
  logic [WIDTH-1:0] data_d, duty_d;

`ifdef PWM_RAMP_SOFT_STOP_EN
  logic soft_q;

  // Soft stop only once PWM is enabled and a ramp is in progress.
  assign soft_take = stop && !soft_q && (state == S_WAIT || state == S_STEP);
  assign soft_act  = soft_q || soft_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        soft_q <= 1'b0;
    else if (state == S_IDLE && start) soft_q <= 1'b0;
    else if (soft_take)                soft_q <= 1'b1;
  end
`else
  assign soft_take = 1'b0;
  assign soft_act  = 1'b0;
`endif

  assign stop_hit = stop && (state != S_IDLE) && (state != S_STOP) && !soft_act;
  assign eff_tgt  = soft_take ? '0 : tgt_q;
  assign at_tgt   = (cur_duty == eff_tgt);

  // Step arithmetic in WIDTH+1 bits so neither direction can wrap past the target.
  always_comb begin
    up_sum  = {1'b0, cur_duty} + {1'b0, step_q};
    dn_diff = {1'b0, cur_duty} - {1'b0, step_q};
    step_val = cur_duty;
    if (cur_duty < eff_tgt)
      step_val = (up_sum > {1'b0, eff_tgt}) ? eff_tgt : up_sum[WIDTH-1:0];
    else if (cur_duty > eff_tgt)
      step_val = (dn_diff[WIDTH] || dn_diff[WIDTH-1:0] < eff_tgt) ? eff_tgt : dn_diff[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_PRESC;
      S_PRESC:  next_state = S_PERIOD;
      S_PERIOD: next_state = S_DUTY0;
      S_DUTY0:  next_state = S_CTRL;
      S_CTRL, S_STEP: begin
        if (at_tgt)                next_state = soft_act ? S_STOP : S_DONE;
        else if (ivl_q == IW'(1))  next_state = S_STEP;
        else                       next_state = S_WAIT;
      end
      S_WAIT:   if (cnt_q == ivl_q - IW'(1)) next_state = S_STEP;
      S_DONE:   next_state = S_IDLE;
      S_STOP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (stop_hit) next_state = S_STOP;
  end

  // Outputs are decoded from next_state and registered, so each write appears in its own state cycle.
  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    duty_d  = cur_duty;
    done_d  = 1'b0;
    busy_d  = (next_state != S_IDLE);
    case (next_state)
      S_PRESC:  begin wr_en_d = 1'b1; addr_d = ADDR_PRESC;  data_d = (state == S_IDLE) ? presc_cfg : presc_q; end
      S_PERIOD: begin wr_en_d = 1'b1; addr_d = ADDR_PERIOD; data_d = period_q; end
      S_DUTY0:  begin wr_en_d = 1'b1; addr_d = ADDR_DUTY;   data_d = '0; duty_d = '0; end
      S_CTRL:   begin wr_en_d = 1'b1; addr_d = ADDR_CTRL;   data_d = {{(WIDTH-2){1'b0}}, mode_q, 1'b1}; end
      S_STEP:   begin wr_en_d = 1'b1; addr_d = ADDR_DUTY;   data_d = step_val; duty_d = step_val; end
      S_STOP:   begin wr_en_d = 1'b1; addr_d = ADDR_CTRL;   data_d = {{(WIDTH-2){1'b0}}, mode_q, 1'b0}; end
      S_DONE:   done_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cur_duty    <= '0;
    end else begin
      reg_wr_en   <= wr_en_d;
      reg_addr    <= addr_d;
      reg_wr_data <= data_d;
      busy        <= busy_d;
      done        <= done_d;
      cur_duty    <= duty_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      presc_q  <= '0;
      period_q <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      ivl_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_q   <= mode_cfg;
        presc_q  <= presc_cfg;
        period_q <= period_cfg;
        tgt_q    <= (target_duty > period_cfg) ? period_cfg : target_duty;
        step_q   <= (step_size == '0) ? WIDTH'(1) : step_size;
        ivl_q    <= (interval == '0) ? IW'(1) : interval;
      end else if (soft_take) begin
        tgt_q    <= '0;
      end
      if (next_state == S_WAIT && state != S_WAIT) cnt_q <= IW'(1);
      else if (state == S_WAIT)                    cnt_q <= cnt_q + IW'(1);
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected register writes/done pulses are queued with
// their cycle stamps at start time and compared against the writes the DUT emits.
module tb_pwm_ramp_ctrl;
  localparam int W  = 16;
  localparam int IW = 16;

  typedef struct packed {
    logic [3:0]   addr;
    logic [W-1:0] data;
    logic [31:0]  cyc;
  } wr_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode_cfg = 1'b0;
  logic [W-1:0]  presc_cfg = '0, period_cfg = '0, target_duty = '0, step_size = '0;
  logic [IW-1:0] interval = '0;
  logic          reg_wr_en, busy, done;
  logic [3:0]    reg_addr;
  logic [W-1:0]  reg_wr_data, cur_duty;

  int          checks = 0, errors = 0;
  logic [31:0] cyc = 0;
  wr_t         exp_q[$], obs_q[$];
  logic [31:0] done_q[$];

  pwm_ramp_ctrl #(.WIDTH(W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cfg(mode_cfg),
    .presc_cfg(presc_cfg), .period_cfg(period_cfg), .target_duty(target_duty),
    .step_size(step_size), .interval(interval), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .busy(busy), .done(done), .cur_duty(cur_duty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr_en) obs_q.push_back({reg_addr, reg_wr_data, cyc});
    if (done)      done_q.push_back(cyc);
  end

  function automatic void exp_w(input logic [3:0] a, input logic [W-1:0] d, input logic [31:0] c);
    exp_q.push_back({a, d, c});
  endfunction

  // Pulses start in cycle 0 (base) and then scrambles the config inputs, which must be ignored.
  task automatic start_ramp(input logic m, input logic [W-1:0] p, pe, t, s,
                            input logic [IW-1:0] iv, output logic [31:0] base);
    @(negedge clk);
    obs_q.delete(); done_q.delete(); exp_q.delete();
    mode_cfg = m; presc_cfg = p; period_cfg = pe; target_duty = t; step_size = s; interval = iv;
    start = 1'b1; base = cyc;
    @(negedge clk);
    start = 1'b0;
    mode_cfg = ~m; presc_cfg = W'($urandom); period_cfg = W'($urandom);
    target_duty = W'($urandom); step_size = W'($urandom); interval = IW'($urandom_range(7, 2));
  endtask

  task automatic wait_idle(output logic [31:0] idle_cyc, output bit to);
    to = 1'b1; idle_cyc = '0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin to = 1'b0; idle_cyc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] base;
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data, busy, done, cur_duty} !== '0) begin
      errors++;
      $display("FAIL reset_init got en=%b a=%0h d=%0d busy=%b done=%b duty=%0d exp all 0",
               reg_wr_en, reg_addr, reg_wr_data, busy, done, cur_duty);
    end
    @(negedge clk); rst_n = 1'b1;
    start_ramp(1'b0, 16'd4, 16'd100, 16'd30, 16'd10, 16'd5, base);
    for (int i = 0; i < 40 && cyc < base + 10; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data, busy, done, cur_duty} !== '0) begin
      errors++;
      $display("FAIL reset_mid got en=%b a=%0h d=%0d busy=%b done=%b duty=%0d exp all 0",
               reg_wr_en, reg_addr, reg_wr_data, busy, done, cur_duty);
    end
    @(negedge clk); rst_n = 1'b1;
    obs_q.delete(); done_q.delete();
    repeat (30) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after got writes=%0d dones=%0d busy=%b exp 0 0 0", obs_q.size(), done_q.size(), busy);
    end
  endtask

  task automatic test_ramp_up;
    logic [31:0] base, idle_c; bit to; wr_t e, o;
    start_ramp(1'b0, 16'd4, 16'd100, 16'd30, 16'd10, 16'd5, base);
    exp_w(4'h3, 16'd4, base + 1);   exp_w(4'h1, 16'd100, base + 2);
    exp_w(4'h2, 16'd0, base + 3);   exp_w(4'h0, 16'd1, base + 4);
    exp_w(4'h2, 16'd10, base + 9);  exp_w(4'h2, 16'd20, base + 14);
    exp_w(4'h2, 16'd30, base + 19);
    wait_idle(idle_c, to);
    checks++;
    if (to || idle_c !== base + 21) begin
      errors++; $display("FAIL ramp_up_idle got c%0d (timeout=%0b) exp c%0d", idle_c - base, to, 21);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL ramp_up_write got none exp a=%0h d=%0d c%0d", e.addr, e.data, e.cyc - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL ramp_up_write got a=%0h d=%0d c%0d exp a=%0h d=%0d c%0d",
                   o.addr, o.data, o.cyc - base, e.addr, e.data, e.cyc - base);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL ramp_up_extra got %0d writes exp 0", obs_q.size()); end
    checks++;
    if (done_q.size() != 1 || done_q[0] !== base + 20) begin
      errors++; $display("FAIL ramp_up_done got %0d pulses exp 1 at c20", done_q.size());
    end
  endtask

  task automatic test_clamp;
    logic [31:0] base, idle_c; bit to; wr_t e, o;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        start_ramp(1'b0, 16'd1, 16'd100, 16'd25, 16'd10, 16'd1, base);
        exp_w(4'h2, 16'd10, base + 5); exp_w(4'h2, 16'd20, base + 6); exp_w(4'h2, 16'd25, base + 7);
      end else begin
        start_ramp(1'b0, 16'd1, 16'd100, 16'd150, 16'd50, 16'd0, base);
        exp_w(4'h2, 16'd50, base + 5); exp_w(4'h2, 16'd100, base + 6);
      end
      exp_q.push_front({4'h0, 16'd1, base + 4}); exp_q.push_front({4'h2, 16'd0, base + 3});
      exp_q.push_front({4'h1, 16'd100, base + 2}); exp_q.push_front({4'h3, 16'd1, base + 1});
      wait_idle(idle_c, to);
      checks++;
      if (to || idle_c !== base + 9 - run) begin
        errors++; $display("FAIL clamp_idle run%0d got c%0d exp c%0d", run, idle_c - base, 9 - run);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (obs_q.size() == 0) begin
          errors++; $display("FAIL clamp_write got none exp a=%0h d=%0d c%0d", e.addr, e.data, e.cyc - base);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL clamp_write run%0d got a=%0h d=%0d c%0d exp a=%0h d=%0d c%0d",
                     run, o.addr, o.data, o.cyc - base, e.addr, e.data, e.cyc - base);
          end
        end
      end
      checks++;
      if (obs_q.size() != 0 || done_q.size() != 1 || done_q[0] !== base + 8 - run) begin
        errors++; $display("FAIL clamp_done run%0d got extra=%0d dones=%0d exp 0 1", run, obs_q.size(), done_q.size());
      end
    end
    checks++;
    if (cur_duty !== 16'd100) begin errors++; $display("FAIL clamp_duty got %0d exp 100", cur_duty); end
  endtask

  task automatic test_ramp_down;
    logic [31:0] base, idle_c; bit to; wr_t e, o;
    start_ramp(1'b1, 16'd2, 16'd100, 16'd5, 16'd0, 16'd2, base);
    exp_w(4'h3, 16'd2, base + 1); exp_w(4'h1, 16'd100, base + 2);
    exp_w(4'h2, 16'd0, base + 3); exp_w(4'h0, 16'd3, base + 4);
    for (int k = 1; k <= 5; k++) exp_w(4'h2, W'(k), base + 4 + 2 * k);
    wait_idle(idle_c, to);
    checks++;
    if (to || idle_c !== base + 16) begin
      errors++; $display("FAIL down_idle got c%0d exp c16", idle_c - base);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL down_write got none exp a=%0h d=%0d c%0d", e.addr, e.data, e.cyc - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL down_write got a=%0h d=%0d c%0d exp a=%0h d=%0d c%0d",
                   o.addr, o.data, o.cyc - base, e.addr, e.data, e.cyc - base);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 1 || done_q[0] !== base + 15) begin
      errors++; $display("FAIL down_done got extra=%0d dones=%0d exp 0 1 at c15", obs_q.size(), done_q.size());
    end
  endtask

`ifndef PWM_RAMP_SOFT_STOP_EN
  task automatic test_stop;
    logic [31:0] base, idle_c; bit to; wr_t e, o;
    start_ramp(1'b1, 16'd4, 16'd100, 16'd50, 16'd10, 16'd5, base);
    exp_w(4'h3, 16'd4, base + 1); exp_w(4'h1, 16'd100, base + 2);
    exp_w(4'h2, 16'd0, base + 3); exp_w(4'h0, 16'd3, base + 4);
    exp_w(4'h2, 16'd10, base + 9); exp_w(4'h2, 16'd20, base + 14);
    exp_w(4'h0, 16'd2, base + 16);
    for (int i = 0; i < 40 && cyc < base + 10; i++) @(negedge clk);
    start = 1'b1; target_duty = 16'd7; step_size = 16'd1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && cyc < base + 15; i++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(idle_c, to);
    checks++;
    if (to || idle_c !== base + 17) begin
      errors++; $display("FAIL stop_idle got c%0d exp c17", idle_c - base);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL stop_write got none exp a=%0h d=%0d c%0d", e.addr, e.data, e.cyc - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL stop_write got a=%0h d=%0d c%0d exp a=%0h d=%0d c%0d",
                   o.addr, o.data, o.cyc - base, e.addr, e.data, e.cyc - base);
        end
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_after got writes=%0d dones=%0d busy=%b exp 0 0 0", obs_q.size(), done_q.size(), busy);
    end
  endtask
`else
  task automatic test_soft_stop;
    logic [31:0] base, idle_c; bit to; wr_t e, o;
    start_ramp(1'b0, 16'd4, 16'd100, 16'd50, 16'd10, 16'd5, base);
    exp_w(4'h3, 16'd4, base + 1); exp_w(4'h1, 16'd100, base + 2);
    exp_w(4'h2, 16'd0, base + 3); exp_w(4'h0, 16'd1, base + 4);
    exp_w(4'h2, 16'd10, base + 9); exp_w(4'h2, 16'd20, base + 14); exp_w(4'h2, 16'd30, base + 19);
    exp_w(4'h2, 16'd20, base + 24); exp_w(4'h2, 16'd10, base + 29); exp_w(4'h2, 16'd0, base + 34);
    exp_w(4'h0, 16'd0, base + 35);
    for (int i = 0; i < 40 && cyc < base + 20; i++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(idle_c, to);
    checks++;
    if (to || idle_c !== base + 36) begin
      errors++; $display("FAIL soft_idle got c%0d exp c36", idle_c - base);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL soft_write got none exp a=%0h d=%0d c%0d", e.addr, e.data, e.cyc - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL soft_write got a=%0h d=%0d c%0d exp a=%0h d=%0d c%0d",
                   o.addr, o.data, o.cyc - base, e.addr, e.data, e.cyc - base);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL soft_after got writes=%0d dones=%0d exp 0 0", obs_q.size(), done_q.size());
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    test_ramp_up;
    test_clamp;
    test_ramp_down;
`ifndef PWM_RAMP_SOFT_STOP_EN
    test_stop;
`else
    test_soft_stop;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
